in_vitro_assay_sequencer: RTL
=============================

IN_VITRO_ASSAY_SEQUENCER -- requirements
Module: in_vitro_assay_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 9: number of mixer/detector assay channels (2..16).
REQ-002 SHALL have parameter W, default 12: detector sample width in bits.
REQ-003 SHALL have parameter LOAD_CYCLES, default 4: reagent-load valve time per channel (1..255).
REQ-004 SHALL have parameter MIX_CYCLES, default 16: mixer run time per channel (1..65535).
REQ-005 SHALL have parameter DET_CYCLES, default 8: detector samples accumulated per channel (1..256).
REQ-006 SHALL define CW = max(1, clog2(N_CH)) and SW = W+8.
REQ-007 SHALL have port clk, input, 1: single clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port start, input, 1: begin a run (sampled only in IDLE).
REQ-010 SHALL have port abort, input, 1: terminate the current run.
REQ-011 SHALL have port ch_mask, input, N_CH: enabled channels, captured at start.
REQ-012 SHALL have port load_valve, output, N_CH: one-hot inlet valve drive for both inputs of the active channel's mixer.
REQ-013 SHALL have port mix_en, output, N_CH: one-hot mixer drive.
REQ-014 SHALL have port det_sel, output, CW: index of the detector being sampled.
REQ-015 SHALL have port det_sample, input, W: unsigned fluorescence sample.
REQ-016 SHALL have port res_valid, output, 1, and port res_ready, input, 1: result handshake.
REQ-017 SHALL have port res_ch, output, CW, and port res_sum, output, SW: the result's channel index and its accumulated samples.
REQ-018 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-019 SHALL have port done, output, 1: one-cycle pulse at the end of a run.

Function
REQ-020 SHALL implement the states IDLE, SCAN, LOAD, MIX, DETECT, REPORT and FINISH.
REQ-021 IDLE: when start=1, SHALL latch ch_mask into mask_q, set the channel index ch to 0, and go to SCAN.
REQ-022 SCAN (1 cycle per channel examined): if ch>=N_CH, SHALL go to FINISH; else if mask_q[ch]=1, SHALL go to LOAD; else SHALL increment ch and stay in SCAN.
REQ-023 LOAD: SHALL assert load_valve[ch] for exactly LOAD_CYCLES cycles, then go to MIX.
REQ-024 MIX: SHALL assert mix_en[ch] for exactly MIX_CYCLES cycles, then go to DETECT.
REQ-025 DETECT: SHALL drive det_sel=ch, clear the accumulator on entry, and add det_sample on each of DET_CYCLES consecutive cycles, starting with the first DETECT cycle.
REQ-026 Accumulation SHALL be unsigned, SW bits wide, and SHALL never overflow within the parameter range.
REQ-027 After the last sample, SHALL go to REPORT with res_sum equal to the full sum and res_ch equal to ch.
REQ-028 REPORT: SHALL hold res_valid=1 with res_sum and res_ch stable until res_ready=1; on that cycle SHALL increment ch and go to SCAN.
REQ-029 A result SHALL NOT be dropped or overwritten while res_valid=1.
REQ-030 FINISH: SHALL assert done for one cycle and return to IDLE.
REQ-031 If mask_q is all zero, a run SHALL be SCAN for N_CH+1 cycles, then FINISH, and SHALL produce no results.
REQ-032 abort=1 in any state except IDLE SHALL go to FINISH on the next cycle: valves/mixers off, res_valid dropped, pending result discarded.
REQ-033 abort has priority over res_ready when both are high in the same cycle.
REQ-034 abort=1 in IDLE SHALL have no effect; abort and start both high in IDLE SHALL start the run.
REQ-035 start SHALL be ignored outside IDLE.
REQ-036 ch_mask changes during a run SHALL have no effect.
REQ-037 load_valve, mix_en and res_valid SHALL be registered outputs.
REQ-038 At most one bit of load_valve|mix_en SHALL be high in any cycle.
REQ-039 load_valve and mix_en SHALL never both be nonzero in the same cycle.

Reset
REQ-040 rst=1 SHALL, on the next rising edge, force state IDLE and set load_valve=0, mix_en=0, det_sel=0, res_valid=0, res_ch=0, res_sum=0, busy=0, done=0, mask_q=0 and ch=0.
REQ-041 rst SHALL take priority over start and abort.
REQ-042 rst asserted mid-run SHALL discard all progress without issuing done.

Verification
REQ-043 Defaults, ch_mask=9'h005, det_sample held at 100, res_ready=1 -> two results: (ch 0, sum 800) then (ch 2, sum 800); done once; busy falls with done.
REQ-044 ch_mask=9'h001, res_ready held 0 for 20 cycles after res_valid -> res_valid, res_ch=0 and res_sum stay stable for 20 cycles; FINISH follows the handshake.
REQ-045 ch_mask=0 -> no results; done pulses exactly N_CH+2 cycles after start.
REQ-046 abort during MIX of channel 1 -> mix_en=0 next cycle, done one cycle later, no result for channel 1.
REQ-047 rst during REPORT with res_valid=1 -> all outputs at reset values the next cycle; a following start runs normally.
REQ-048 W=12, DET_CYCLES=256, det_sample=4095 -> res_sum=1048320 with no overflow.

Source files
------------

// File: rtl/in_vitro_assay_sequencer.sv
// rtl/in_vitro_assay_sequencer.sv - per-channel load/mix/detect assay sequencer with result handshake
module in_vitro_assay_sequencer #(
    parameter int N_CH        = 9,
    parameter int W           = 12,
    parameter int LOAD_CYCLES = 4,
    parameter int MIX_CYCLES  = 16,
    parameter int DET_CYCLES  = 8,
    localparam int CW = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH),
    localparam int SW = W + 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_mask,
    output logic [N_CH-1:0] load_valve,
    output logic [N_CH-1:0] mix_en,
    output logic [CW-1:0]   det_sel,
    input  logic [W-1:0]    det_sample,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [CW-1:0]   res_ch,
    output logic [SW-1:0]   res_sum,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE, SCAN, LOAD, MIX, DETECT, REPORT, FINISH
    } state_t;

    localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] MIX_LAST  = 16'(MIX_CYCLES - 1);
    localparam logic [15:0] DET_LAST  = 16'(DET_CYCLES - 1);
    localparam logic [CW:0] CH_END    = (CW + 1)'(N_CH);
    localparam logic [CW:0] CH_ONE    = (CW + 1)'(1);
    localparam int          MPW       = 2 ** (CW + 1);

    state_t          state, state_n;
    // ch needs one extra bit so the scan can step past the last channel
    logic [CW:0]     ch, ch_n;
    logic [15:0]     cnt;
    logic [N_CH-1:0] mask_q;
    logic [MPW-1:0]  mask_pad;
    logic [N_CH-1:0] ch_onehot;

    assign mask_pad  = {{(MPW - N_CH){1'b0}}, mask_q};
    assign ch_onehot = N_CH'(1) << ch_n;
    assign det_sel   = ch[CW-1:0];
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);

    always_comb begin
        state_n = state;
        ch_n    = ch;
        case (state)
            IDLE:    if (start) begin
                         state_n = SCAN;
                         ch_n    = '0;
                     end
            SCAN:    if (ch >= CH_END)    state_n = FINISH;
                     else if (mask_pad[ch]) state_n = LOAD;
                     else                  ch_n    = ch + CH_ONE;
            LOAD:    if (cnt == LOAD_LAST) state_n = MIX;
            MIX:     if (cnt == MIX_LAST)  state_n = DETECT;
            DETECT:  if (cnt == DET_LAST)  state_n = REPORT;
            REPORT:  if (res_ready) begin
                         state_n = SCAN;
                         ch_n    = ch + CH_ONE;
                     end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // FINISH always drains to IDLE so done stays a single-cycle pulse
        if (abort && state != IDLE && state != FINISH)
            state_n = FINISH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            cnt        <= '0;
            mask_q     <= '0;
            load_valve <= '0;
            mix_en     <= '0;
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_sum    <= '0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            cnt   <= (state_n != state) ? 16'd0 : cnt + 16'd1;
            if (state == IDLE && start)
                mask_q <= ch_mask;
            // outputs are registered from the next state so they align with it
            load_valve <= (state_n == LOAD) ? ch_onehot : '0;
            mix_en     <= (state_n == MIX)  ? ch_onehot : '0;
            res_valid  <= (state_n == REPORT);
            if (state == DETECT) begin
                res_ch  <= ch[CW-1:0];
                res_sum <= ((cnt == 16'd0) ? '0 : res_sum) + SW'(det_sample);
            end
        end
    end

endmodule
